// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TAG  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam int WORD_WIDTH     = 32;
  localparam int LINE_WIDTH     = 128;
  localparam int WORDS_PER_LINE = 4;
  localparam int OFFSET_BITS    = 4;

  function automatic int tag_width(input int idx_bits);
    return 32 - OFFSET_BITS - idx_bits;
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data storage for the instruction cache: synchronous write,
// combinational read, valid bits cleared by synchronous reset.
module icache_line_store
  import icache_pkg::*;
#(
  parameter int NUM_LINES = 8,
  parameter int IDX_W     = 3,
  parameter int TAG_W     = 25
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IDX_W-1:0]      rd_index,
  output logic                  rd_valid,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [LINE_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_index,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [LINE_WIDTH-1:0] wr_data
);

  logic [NUM_LINES-1:0]  valid;
  logic [TAG_W-1:0]      tags  [NUM_LINES];
  logic [LINE_WIDTH-1:0] lines [NUM_LINES];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  // Tag and data carry no reset; the valid bit alone qualifies them.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      tags[wr_index]  <= wr_tag;
      lines[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_data  = lines[rd_index];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache in front of InstructionMemory.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
//
// state | meaning
// IDLE  | waiting for req; latches the fetch address
// TAG   | lookup; deliver on hit, issue line request on miss
// WAIT  | count down memory latency, fill line on terminal count
module instruction_cache
  import icache_pkg::*;
#(
  parameter int NUM_LINES   = 8,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           inputAddress,
  input  logic                  req,
  output logic [WORD_WIDTH-1:0] instruction,
  output logic                  ready,
  output logic                  hit,
  output logic [31:0]           mem_address,
  input  logic [LINE_WIDTH-1:0] data_line
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = tag_width(IDX_W);
  localparam int CNT_W = $clog2(MEM_LATENCY + 1);
  localparam int SEL_W = $clog2(WORDS_PER_LINE);

  state_t                  state, state_next;
  logic [31:2]             req_addr, req_addr_next;
  logic                    miss_flag, miss_flag_next;
  logic [CNT_W-1:0]        cnt, cnt_next;
  logic                    ready_next, hit_next;
  logic [WORD_WIDTH-1:0]   instr_next;
  logic [31:0]             mem_addr_next;
  logic                    fill;

  logic [IDX_W-1:0]        idx;
  logic [TAG_W-1:0]        tag;
  logic [SEL_W-1:0]        sel;
  logic                    line_valid;
  logic [TAG_W-1:0]        line_tag;
  logic [LINE_WIDTH-1:0]   line_data;
  logic                    lookup_hit;
  logic [WORD_WIDTH-1:0]   sel_word;
  logic                    unused_byte_bits;

  assign unused_byte_bits = ^inputAddress[1:0];

  assign idx        = req_addr[OFFSET_BITS +: IDX_W];
  assign tag        = req_addr[31 -: TAG_W];
  assign sel        = req_addr[3:2];
  assign lookup_hit = line_valid && (line_tag == tag);
  assign sel_word   = line_data[{sel, 5'b0} +: WORD_WIDTH];

  icache_line_store #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_line_store (
    .clk      (clk),
    .rst      (rst),
    .rd_index (idx),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (fill),
    .wr_index (idx),
    .wr_tag   (tag),
    .wr_data  (data_line)
  );

  always_comb begin
    state_next     = state;
    req_addr_next  = req_addr;
    miss_flag_next = miss_flag;
    cnt_next       = cnt;
    ready_next     = 1'b0;
    hit_next       = 1'b0;
    instr_next     = instruction;
    mem_addr_next  = mem_address;
    fill           = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          req_addr_next  = inputAddress[31:2];
          miss_flag_next = 1'b0;
          state_next     = TAG;
        end
      end
      TAG: begin
        if (lookup_hit) begin
          instr_next = sel_word;
          ready_next = 1'b1;
          hit_next   = !miss_flag;
          state_next = IDLE;
        end else begin
          mem_addr_next  = {req_addr[31:4], 4'b0};
          miss_flag_next = 1'b1;
          cnt_next       = CNT_W'(MEM_LATENCY);
          state_next     = WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          fill       = 1'b1;
          state_next = TAG;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req_addr    <= '0;
      miss_flag   <= 1'b0;
      cnt         <= '0;
      ready       <= 1'b0;
      hit         <= 1'b0;
      instruction <= '0;
      mem_address <= '0;
    end else begin
      state       <= state_next;
      req_addr    <= req_addr_next;
      miss_flag   <= miss_flag_next;
      cnt         <= cnt_next;
      ready       <= ready_next;
      hit         <= hit_next;
      instruction <= instr_next;
      mem_address <= mem_addr_next;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (ready_next && hit_next) hit_count <= hit_count + 32'd1;
      if (state == TAG && !lookup_hit) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Self-checking bench for instruction_cache: vector table plus hand-written
// sequences for back-to-back requests, req during WAIT and reset mid-miss.
module tb_instruction_cache;

  localparam int LAT = 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         req;
  logic [31:0]  inputAddress;
  logic [31:0]  instruction;
  logic         ready;
  logic         hit;
  logic [31:0]  mem_address;
  logic [127:0] data_line;
`ifdef ICACHE_STATS_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [31:0] instr;
    logic        hit;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [31:0] addr;
    logic        exp_hit;
    logic [31:0] exp_instr;
    logic [31:0] exp_mem;
  } vec_t;
  vec_t vecs[10];

  instruction_cache #(.NUM_LINES(8), .MEM_LATENCY(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .inputAddress (inputAddress),
    .req          (req),
    .instruction  (instruction),
    .ready        (ready),
    .hit          (hit),
    .mem_address  (mem_address),
    .data_line    (data_line)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: word k of the line at address a is (0x11111111*(k+1)) ^ a.
  function automatic logic [127:0] mem_line(input logic [31:0] a);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[32*k +: 32] = (32'h11111111 * 32'(k + 1)) ^ a;
    return l;
  endfunction

  assign data_line = mem_line(mem_address);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_ready", 32'(ready), 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_instr", instruction, e.instr);
        check("sb_hit", 32'(hit), 32'(e.hit));
      end
    end
  end

  task automatic run_req(input logic [31:0] a, input logic exp_hit, input logic [31:0] exp_instr,
                         input logic [31:0] exp_mem, input string name);
    int n;
    bit seen;
    @(negedge clk);
    req = 1'b1;
    inputAddress = a;
    sb.push_back('{exp_instr, exp_hit});
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (ready === 1'b1) seen = 1'b1;
    end
    check({name, "_latency"}, 32'(n), exp_hit ? 32'd1 : 32'(2 + LAT));
    check({name, "_mem"}, mem_address, exp_mem);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0000000A, 1'b0, 32'h33333333, 32'h00000000};
    vecs[1] = '{32'h0000000A, 1'b1, 32'h33333333, 32'h00000000};
    vecs[2] = '{32'h0000000F, 1'b1, 32'h44444444, 32'h00000000};
    vecs[3] = '{32'h0000008A, 1'b0, 32'h333333B3, 32'h00000080};
    vecs[4] = '{32'h0000000A, 1'b0, 32'h33333333, 32'h00000000};
    vecs[5] = '{32'h00000014, 1'b0, 32'h22222232, 32'h00000010};
    vecs[6] = '{32'h0000001C, 1'b1, 32'h44444454, 32'h00000010};
    vecs[7] = '{32'h00000008, 1'b1, 32'h33333333, 32'h00000010};
    vecs[8] = '{32'h0000007C, 1'b0, 32'h44444434, 32'h00000070};
    vecs[9] = '{32'h12345678, 1'b0, 32'h21076543, 32'h12345670};

    // Reset asserted together with req: reset must win.
    rst = 1'b1;
    req = 1'b1;
    inputAddress = 32'h0000000A;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_hit", 32'(hit), 32'd0);
    check("rst_instr", instruction, 32'd0);
    check("rst_mem", mem_address, 32'd0);
`ifdef ICACHE_STATS_EN
    check("rst_hit_count", hit_count, 32'd0);
    check("rst_miss_count", miss_count, 32'd0);
`endif
    rst = 1'b0;
    req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_after_rst", 32'(ready), 32'd0);
    end

    for (int i = 0; i < 10; i++) begin
      run_req(vecs[i].addr, vecs[i].exp_hit, vecs[i].exp_instr, vecs[i].exp_mem, $sformatf("vec%0d", i));
`ifdef ICACHE_STATS_EN
      if (i == 2) begin
        check("stats_hit_count", hit_count, 32'd2);
        check("stats_miss_count", miss_count, 32'd1);
      end
`endif
    end

    // Back-to-back: a req during the ready cycle is accepted.
    @(negedge clk);
    req = 1'b1;
    inputAddress = 32'h0000000A;
    sb.push_back('{32'h33333333, 1'b1});
    @(posedge clk);
    @(negedge clk);
    check("b2b_tag_cycle", 32'(ready), 32'd0);
    @(negedge clk);
    check("b2b_first_ready", 32'(ready), 32'd1);
    inputAddress = 32'h0000000F;
    sb.push_back('{32'h44444444, 1'b1});
    @(negedge clk);
    req = 1'b0;
    check("b2b_gap", 32'(ready), 32'd0);
    @(negedge clk);
    check("b2b_second_ready", 32'(ready), 32'd1);

    // req pulsed during WAIT is ignored.
    @(negedge clk);
    req = 1'b1;
    inputAddress = 32'h0000008A;
    sb.push_back('{32'h333333B3, 1'b0});
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    req = 1'b1;
    inputAddress = 32'h00000010;
    @(negedge clk);
    req = 1'b0;
    check("wait_no_early_ready", 32'(ready), 32'd0);
    @(negedge clk);
    check("wait_ready", 32'(ready), 32'd1);
    check("wait_mem", mem_address, 32'h00000080);
    repeat (6) begin
      @(negedge clk);
      check("wait_no_extra_ready", 32'(ready), 32'd0);
    end

    // Reset in WAIT aborts the fill.
    @(negedge clk);
    req = 1'b1;
    inputAddress = 32'h0000009A;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    check("abort_mem_issued", mem_address, 32'h00000090);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_mem_reset", mem_address, 32'd0);
    repeat (5) begin
      @(negedge clk);
      check("abort_no_ready", 32'(ready), 32'd0);
    end
    run_req(32'h00000014, 1'b0, 32'h22222232, 32'h00000010, "post_rst_valid_cleared");
    run_req(32'h0000009A, 1'b0, 32'h333333A3, 32'h00000090, "post_rst_same_addr");
`ifdef ICACHE_STATS_EN
    check("post_rst_hit_count", hit_count, 32'd0);
    check("post_rst_miss_count", miss_count, 32'd2);
`endif

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instruction_cache.md
# instruction_cache

Direct-mapped, read-only instruction cache between the fetch stage and `InstructionMemory`. It takes 32-bit byte addresses from fetch and returns one 32-bit instruction per request. On a miss it requests a 128-bit, four-word line from `InstructionMemory`, waits a fixed latency, fills the line, then serves the word. It is the direct consumer of `InstructionMemory.data_line` and the driver of its `inputAddress`.

## Interface
- `NUM_LINES`, 8: number of cache lines; must be a power of two, at least 2.
- `MEM_LATENCY`, 1: rising edges from `mem_address` becoming stable until `data_line` is valid; must be at least 1.
- `clk` input 1: the single clock; all state changes on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `inputAddress` input 32: fetch byte address; sampled only with `req` in IDLE.
- `req` input 1: fetch request.
- `instruction` output 32: fetched word; valid while `ready` is high.
- `ready` output 1: one-cycle pulse, instruction delivered.
- `hit` output 1: high together with `ready` when the original lookup hit.
- `mem_address` output 32: line-aligned address to `InstructionMemory`; bits [3:0] are always 0.
- `data_line` input 128: line returned by `InstructionMemory`.

## Operation
- Address fields (IDX = log2(NUM_LINES)):
  - [1:0]: ignored.
  - [3:2]: word select.
  - [3+IDX:4]: index.
  - [31:4+IDX]: tag.
- Word k of a line is bits [32k+31:32k] of `data_line`.
- Per-line storage: valid bit, tag and 128-bit data.
- FSM states: IDLE, TAG, WAIT.
  - IDLE: when `req` is high, latch `inputAddress`, clear `miss_flag`, go to TAG. When `req` is low, stay.
  - TAG, line valid and tag equal: register `instruction` = selected word, `ready` = 1, `hit` = !`miss_flag`, go to IDLE.
  - TAG, miss: register `mem_address` = {latched[31:4], 4'b0}, set `miss_flag`, load the counter with MEM_LATENCY, go to WAIT.
  - WAIT: decrement the counter. On the edge where the counter equals 1, write `data_line`, tag and valid=1 into the indexed line, then go to TAG. The following lookup then hits and delivers the word with `hit` = 0.
- A miss overwrites the indexed line unconditionally (eviction).
- `req` is ignored outside IDLE; no queueing.
- `mem_address` holds its value until the next miss.

## Timing
- Reset values: state IDLE, every valid bit 0, `ready` 0, `hit` 0, `instruction` 0, `mem_address` 0, counter 0, `miss_flag` 0.
- Reset in any state, including mid-miss, aborts the operation. No fill occurs and the in-flight `data_line` is discarded.
- Let E0 be the edge that accepts `req`.
- Hit: `ready`/`hit` are high in the cycle after E1.
- Miss:
  - `mem_address` is valid from E1.
  - The fill happens at E(1+MEM_LATENCY).
  - `ready` is high after E(2+MEM_LATENCY).
- `ready` is high for exactly one cycle, during which the FSM is in IDLE. A `req` in that cycle is accepted, so the maximum throughput is one instruction every 2 cycles.
- `rst` and `req` asserted together: reset wins.

## Configuration
- `ICACHE_STATS_EN` defined: adds outputs `hit_count` [31:0] and `miss_count` [31:0].
  - `hit_count` increments on each `ready` with `hit` = 1.
  - `miss_count` increments on each TAG→WAIT transition.
  - Both wrap modulo 2^32 and reset to 0.
- `ICACHE_STATS_EN` undefined: neither port nor counter exists; all other behaviour is identical.

## Structure
- Shared package `icache_pkg` contains:
  - state enum (IDLE, TAG, WAIT);
  - WORD_WIDTH=32, LINE_WIDTH=128, WORDS_PER_LINE=4, OFFSET_BITS=4;
  - a function computing tag width from the index width.
- One sub-module, `icache_line_store`:
  - valid, tag and data arrays;
  - synchronous write, combinational read;
  - synchronous clear of all valid bits on `rst`.
- The FSM, counter and output registers stay in `instruction_cache`.

## Test plan
- Reset, then `req` with `inputAddress`=0x0000000A; memory returns line 0x44444444_33333333_22222222_11111111.
  - Required: miss, `mem_address`=0x00000000, `ready` after E3 with `instruction`=0x33333333 and `hit`=0.
- Repeat 0x0000000A.
  - Required: `ready` after E1, `hit`=1, `instruction`=0x33333333, `mem_address` unchanged.
- `req` with 0x0000000F.
  - Required: hit, `instruction`=0x44444444.
- `req` with 0x0000008A (same index 0, different tag).
  - Required: miss, `mem_address`=0x00000080, line evicted.
  - A following `req` with 0x0000000A misses again.
- Miss in progress:
  - Pulse `req` with 0x00000010 during WAIT; it is ignored and no extra `ready` occurs.
  - Assert `rst` during WAIT; `ready` stays 0. The next `req` with the same address misses.
- With `ICACHE_STATS_EN` defined, after the first three scenarios: `hit_count`=2, `miss_count`=1.
